// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory
// and buffers returned words with their addresses in an in-order FIFO.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc;
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   aq        [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, aq_rd, aq_wr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW:0]   inflight;
  logic          pop, accept, rsp_ok, push;

  assign pop    = instr_valid & instr_ready;
  assign rsp_ok = imem_rsp_valid & (outstanding != '0);
  assign push   = rsp_ok & ~redirect & (discard == '0);
  assign accept = imem_req_valid & imem_req_ready;

  // Slots already committed (buffered or in flight), crediting a pop this cycle
  assign inflight = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);

  assign imem_req_valid = rst_n & ~redirect & (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;

  assign instr_valid = (count != '0);
  assign instr       = fifo_word[rd_ptr];
  assign instr_pc    = fifo_addr[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else begin
      if (redirect)    pc <= {redirect_pc[31:2], 2'b00};
      else if (accept) pc <= pc + 32'd4;

      if (accept) aq_wr <= aq_wr + 1'b1;
      if (rsp_ok) aq_rd <= aq_rd + 1'b1;

      outstanding <= outstanding + CW'(accept) - CW'(rsp_ok);

      // Everything still in flight at a redirect belongs to the abandoned stream
      if (redirect)                    discard <= outstanding - CW'(rsp_ok);
      else if (rsp_ok && discard != '0) discard <= discard - 1'b1;

      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_word[i] <= '0;
        fifo_addr[i] <= '0;
        aq[i]        <= '0;
      end
    end else begin
      if (accept) aq[aq_wr] <= pc;
      if (push) begin
        fifo_word[wr_ptr] <= imem_rsp_data;
        fifo_addr[wr_ptr] <= aq[aq_rd];
      end
    end
  end

  rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: fixed-latency memory model plus an in-order scoreboard
// of expected {pc, word} pairs pushed at request accept and popped at decoder consume.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  int unsigned lat;
  int unsigned cyc;
  int          checks   = 0;
  int          failures = 0;

  logic        s_acc, s_pop, s_valid, s_reqv;
  logic [31:0] s_addr, s_pc, s_instr;

  // One clock cycle: memory drives its response, outputs are sampled mid-cycle,
  // the scoreboard is updated, then time advances to just after the next edge.
  task automatic step();
    rsp_t        r;
    logic [31:0] e;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = r.addr + 32'h100;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #2;
    s_reqv  = imem_req_valid;
    s_acc   = imem_req_valid & imem_req_ready;
    s_pop   = instr_valid & instr_ready;
    s_valid = instr_valid;
    s_addr  = imem_req_addr;
    s_pc    = instr_pc;
    s_instr = instr;
    if (redirect) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL req_during_redirect: got %b expected 0", imem_req_valid);
      end
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (s_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_instr: got pc %h with nothing outstanding", s_pc);
        end else begin
          e = exp_q.pop_front();
          if (s_pc !== e) begin
            failures++;
            $display("FAIL instr_pc: got %h expected %h", s_pc, e);
          end
          checks++;
          if (s_instr !== e + 32'h100) begin
            failures++;
            $display("FAIL instr_word: got %h expected %h", s_instr, e + 32'h100);
          end
        end
      end
      if (s_acc) begin
        checks++;
        if (s_addr !== model_pc) begin
          failures++;
          $display("FAIL req_addr: got %h expected %h", s_addr, model_pc);
        end
        pend.push_back('{due: cyc + lat, addr: s_addr});
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int unsigned l);
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend.delete();
    exp_q.delete();
    model_pc = RPC;
    lat      = l;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    @(posedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== RPC)   begin failures++; $display("FAIL rst_req_addr: got %h expected %h", imem_req_addr, RPC); end
    checks++; if (instr_valid !== 1'b0)    begin failures++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0)         begin failures++; $display("FAIL rst_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0)      begin failures++; $display("FAIL rst_instr_pc: got %h expected 0", instr_pc); end
  endtask

  task automatic test_stream();
    do_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 3) begin
        checks++;
        if (!s_acc || s_addr !== 32'(i * 4)) begin
          failures++;
          $display("FAIL stream_req%0d: got acc=%b addr=%h expected acc=1 addr=%h", i, s_acc, s_addr, 32'(i * 4));
        end
      end
      checks++;
      if (s_valid !== (i >= 2)) begin
        failures++;
        $display("FAIL stream_valid_c%0d: got %b expected %b", i, s_valid, (i >= 2));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_pop = 0;
    do_reset(1);
    instr_ready = 1'b0;
    repeat (5) begin
      step();
      if (s_acc) n_acc++;
    end
    checks++; if (n_acc != 2)    begin failures++; $display("FAIL bp_accepts: got %0d expected 2", n_acc); end
    checks++; if (s_reqv !== 1'b0) begin failures++; $display("FAIL bp_req_valid: got %b expected 0", s_reqv); end
    instr_ready = 1'b1;
    repeat (12) begin
      step();
      if (s_pop) n_pop++;
    end
    checks++; if (n_pop != 12)   begin failures++; $display("FAIL bp_resume_pops: got %0d expected 12", n_pop); end
    drain();
  endtask

  task automatic test_redirect();
    do_reset(2);
    step();
    imem_req_ready = 1'b0;
    step();
    imem_req_ready = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    step();
    checks++; if (!s_acc || s_addr !== 32'h40) begin failures++; $display("FAIL redir_req: got acc=%b addr=%h expected acc=1 addr=00000040", s_acc, s_addr); end
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got %b expected 0", s_valid); end
    step();
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL redir_drop_c5: got %b expected 0", s_valid); end
    step();
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL redir_drop_c6: got %b expected 0", s_valid); end
    step();
    checks++; if (!s_valid || s_pc !== 32'h40) begin failures++; $display("FAIL redir_first_pc: got valid=%b pc=%h expected valid=1 pc=00000040", s_valid, s_pc); end
    drain();
  endtask

  task automatic test_req_stall();
    do_reset(1);
    instr_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_reqv !== 1'b1 || s_addr !== 32'h8) begin
        failures++;
        $display("FAIL stall_c%0d: got valid=%b addr=%h expected valid=1 addr=00000008", i, s_reqv, s_addr);
      end
    end
    imem_req_ready = 1'b1;
    step();
    checks++; if (!s_acc || s_addr !== 32'h8) begin failures++; $display("FAIL stall_accept: got acc=%b addr=%h expected acc=1 addr=00000008", s_acc, s_addr); end
    repeat (4) step();
    drain();
  endtask

  task automatic test_double_redirect();
    int n300 = 0;
    do_reset(3);
    instr_ready = 1'b1;
    repeat (6) step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    repeat (15) begin
      step();
      if (s_pop && s_pc[31:8] == 24'h3) n300++;
    end
    checks++; if (n300 == 0) begin failures++; $display("FAIL dbl_new_stream: got %0d words expected >0", n300); end
    drain();
    repeat (4) step();
    checks++; if (dut.discard !== '0)     begin failures++; $display("FAIL dbl_discard: got %0d expected 0", dut.discard); end
    checks++; if (dut.outstanding !== '0) begin failures++; $display("FAIL dbl_outstanding: got %0d expected 0", dut.outstanding); end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset(1);
    instr_ready = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    step();
    checks++; if (!s_acc || s_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top: got acc=%b addr=%h expected acc=1 addr=fffffffc", s_acc, s_addr); end
    step();
    checks++; if (!s_acc || s_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero: got acc=%b addr=%h expected acc=1 addr=00000000", s_acc, s_addr); end
    repeat (4) step();
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid: got %b expected 1", s_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL async_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== RPC)   begin failures++; $display("FAIL async_req_addr: got %h expected %h", imem_req_addr, RPC); end
    checks++; if (instr_valid !== 1'b0)    begin failures++; $display("FAIL async_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0)         begin failures++; $display("FAIL async_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0)      begin failures++; $display("FAIL async_instr_pc: got %h expected 0", instr_pc); end
    pend.delete();
    exp_q.delete();
    model_pc       = RPC;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    step();
    checks++; if (!s_acc || s_addr !== RPC) begin failures++; $display("FAIL restart_req: got acc=%b addr=%h expected acc=1 addr=%h", s_acc, s_addr, RPC); end
    repeat (6) step();
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_req_stall();
    test_double_redirect();
    test_wrap_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
